// File: rtl/frame_window_reader.sv
// Display-side frame buffer reader: maps the VGA raster onto a stored image placed at a
// per-frame offset with integer upscale, mirror and flip. It also delays sync/blank to match
// the BRAM read latency and produces the final 12-bit pixel, with a background fill.
module frame_window_reader #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int HC_W    = 11,
  parameter int VC_W    = 10,
  parameter int ADDR_W  = 17,
  parameter int PIX_W   = 16,
  parameter int RAM_LAT = 2,
  parameter int GRAY    = 0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [HC_W-1:0]   hcount_in,
  input  logic [VC_W-1:0]   vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic [HC_W-1:0]   x0_in,
  input  logic [VC_W-1:0]   y0_in,
  input  logic [1:0]        scale_in,
  input  logic              mirror_in,
  input  logic              flip_in,
  input  logic [11:0]       bg_in,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [11:0]       pixel_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic              in_window_out,
  output logic              frame_start_out
);

  // Total pipeline depth: address register + BRAM latency + output register.
  localparam int L  = RAM_LAT + 2;
  // Window arithmetic is widened by 3 bits so x4 extents never wrap.
  localparam int XW = HC_W + 3;
  localparam int YW = VC_W + 3;

  // Side-band bit positions within one delay-line stage.
  localparam int SideHs     = 0;
  localparam int SideVs     = 1;
  localparam int SideBlank  = 2;
  localparam int SideWin    = 3;
  localparam int SideOrigin = 4;
  localparam int SW         = 5;

  function automatic logic [1:0] scale_shift(input logic [1:0] code);
    case (code)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;  // 00 and the reserved 11 both mean x1
    endcase
  endfunction

  logic              frame_origin;
  logic [HC_W-1:0]   x0_q, x0_eff;
  logic [VC_W-1:0]   y0_q, y0_eff;
  logic [1:0]        shift_q, shift_eff;
  logic              mirror_q, mirror_eff;
  logic              flip_q, flip_eff;

  logic [XW-1:0]     h_ext, x0_ext, dh, cx, rx;
  logic [YW-1:0]     v_ext, y0_ext, dv, cy, ry;
  logic              in_x, in_y, in_win;
  logic [ADDR_W-1:0] addr_d;

  logic [L-2:0][SW-1:0] side_q;
  logic [SW-1:0]        side_in, side_last;
  logic [11:0]          pixel_d;
  logic                 origin_seen_q;
  logic                 unused_pix;

  assign frame_origin = (hcount_in == '0) && (vcount_in == '0);

  // Shadow config: captured only at pixel (0,0) and held for the rest of the frame
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x0_q     <= '0;
      y0_q     <= '0;
      shift_q  <= 2'd0;
      mirror_q <= 1'b0;
      flip_q   <= 1'b0;
    end else if (frame_origin) begin
      x0_q     <= x0_in;
      y0_q     <= y0_in;
      shift_q  <= scale_shift(scale_in);
      mirror_q <= mirror_in;
      flip_q   <= flip_in;
    end
  end

  // Window test and address generation; pixel (0,0) already sees the new frame's config
  always_comb begin
    x0_eff     = frame_origin ? x0_in : x0_q;
    y0_eff     = frame_origin ? y0_in : y0_q;
    shift_eff  = frame_origin ? scale_shift(scale_in) : shift_q;
    mirror_eff = frame_origin ? mirror_in : mirror_q;
    flip_eff   = frame_origin ? flip_in : flip_q;

    h_ext  = XW'(hcount_in);
    x0_ext = XW'(x0_eff);
    dh     = h_ext - x0_ext;
    in_x   = (h_ext >= x0_ext) && (dh < (XW'(IMG_W) << shift_eff));
    cx     = dh >> shift_eff;
    rx     = mirror_eff ? (XW'(IMG_W - 1) - cx) : cx;

    v_ext  = YW'(vcount_in);
    y0_ext = YW'(y0_eff);
    dv     = v_ext - y0_ext;
    in_y   = (v_ext >= y0_ext) && (dv < (YW'(IMG_H) << shift_eff));
    cy     = dv >> shift_eff;
    ry     = flip_eff ? (YW'(IMG_H - 1) - cy) : cy;

    in_win = in_x && in_y;
    addr_d = '0;
    if (in_win && !blank_in) begin
      addr_d = ADDR_W'(ry) * ADDR_W'(IMG_W) + ADDR_W'(rx);
    end
  end

  assign side_in   = {frame_origin, in_win, blank_in, vsync_in, hsync_in};
  assign side_last = side_q[L-2];

  // Address register plus the shared side-band delay line (L-1 stages before the output reg)
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_out <= '0;
      side_q   <= '0;
    end else begin
      addr_out  <= addr_d;
      side_q[0] <= side_in;
      for (int i = 1; i < L - 1; i++) begin
        side_q[i] <= side_q[i-1];
      end
    end
  end

  // Colour selection at the output stage; bg_in is taken live here
  always_comb begin
    pixel_d = '0;
    if (side_last[SideBlank]) begin
      pixel_d = '0;
    end else if (!side_last[SideWin]) begin
      pixel_d = bg_in;
    end else if (GRAY != 0) begin
      pixel_d = {3{pixel_in[PIX_W-1 -: 4]}};
    end else begin
      pixel_d = {pixel_in[15:12], pixel_in[10:7], pixel_in[4:1]};
    end
  end

  // Only some BRAM word bits feed the colour path
  assign unused_pix = ^pixel_in;

  // Output registers; frame_start is edge-detected so it is a single-cycle pulse
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_out       <= '0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      blank_out       <= 1'b0;
      in_window_out   <= 1'b0;
      frame_start_out <= 1'b0;
      origin_seen_q   <= 1'b0;
    end else begin
      pixel_out       <= pixel_d;
      hsync_out       <= side_last[SideHs];
      vsync_out       <= side_last[SideVs];
      blank_out       <= side_last[SideBlank];
      in_window_out   <= side_last[SideWin] && !side_last[SideBlank];
      frame_start_out <= side_last[SideOrigin] && !origin_seen_q;
      origin_seen_q   <= side_last[SideOrigin];
    end
  end

endmodule

// File: tb/tb_frame_window_reader.sv
// Directed, table-driven bench for frame_window_reader with a small BRAM model.
module tb_frame_window_reader;

  localparam int IMG_W = 320, IMG_H = 240, HC_W = 11, VC_W = 10, ADDR_W = 17, PIX_W = 16;
  localparam int RAM_LAT = 2;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [HC_W-1:0]   hcount_in, x0_in;
  logic [VC_W-1:0]   vcount_in, y0_in;
  logic              hsync_in, vsync_in, blank_in, mirror_in, flip_in;
  logic [1:0]        scale_in;
  logic [11:0]       bg_in;
  logic [PIX_W-1:0]  pixel_in;
  logic [ADDR_W-1:0] addr_out;
  logic [11:0]       pixel_out;
  logic              hsync_out, vsync_out, blank_out, in_window_out, frame_start_out;

  int n_checks = 0;
  int n_fail   = 0;

  frame_window_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .HC_W(HC_W), .VC_W(VC_W), .ADDR_W(ADDR_W),
    .PIX_W(PIX_W), .RAM_LAT(RAM_LAT), .GRAY(0)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in), .x0_in(x0_in),
    .y0_in(y0_in), .scale_in(scale_in), .mirror_in(mirror_in), .flip_in(flip_in),
    .bg_in(bg_in), .pixel_in(pixel_in), .addr_out(addr_out), .pixel_out(pixel_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .in_window_out(in_window_out), .frame_start_out(frame_start_out)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model: data appears RAM_LAT cycles after the registered address
  logic [ADDR_W-1:0] ram_a0 = '0, ram_a1 = '0;
  always @(posedge clk_in) begin
    ram_a0 <= addr_out;
    ram_a1 <= ram_a0;
  end

  function automatic logic [15:0] ram_word(input logic [ADDR_W-1:0] a);
    if (a == '0) return 16'hF800;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [11:0] rgb12(input logic [15:0] w);
    return {w[15:12], w[10:7], w[4:1]};
  endfunction

  assign pixel_in = ram_word(ram_a1);

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One raster cycle; returns 1 ns after the edge that sampled it
  task automatic step(input int h, input int v, input logic blk);
    hcount_in = HC_W'(h);
    vcount_in = VC_W'(v);
    blank_in  = blk;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_cfg(input int x0, input int y0, input logic [1:0] sc,
                         input logic mir, input logic flp);
    x0_in = HC_W'(x0); y0_in = VC_W'(y0); scale_in = sc; mirror_in = mir; flip_in = flp;
  endtask

  typedef struct {
    int         x0;
    int         y0;
    logic [1:0] sc;
    logic       mir;
    logic       flp;
    int         h;
    int         v;
    logic       blk;
    int         addr;
    logic       inw;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [11:0] exp_pix;

    vecs = '{
      '{200, 250, 2'b00, 1'b0, 1'b0, 200, 250, 1'b0,     0, 1'b1},
      '{200, 250, 2'b00, 1'b0, 1'b0, 519, 250, 1'b0,   319, 1'b1},
      '{200, 250, 2'b00, 1'b0, 1'b0, 520, 250, 1'b0,     0, 1'b0},
      '{200, 250, 2'b00, 1'b0, 1'b0, 200, 251, 1'b0,   320, 1'b1},
      '{200, 250, 2'b00, 1'b0, 1'b0, 519, 489, 1'b0, 76799, 1'b1},
      '{200, 250, 2'b00, 1'b0, 1'b0, 200, 490, 1'b0,     0, 1'b0},
      '{200, 250, 2'b00, 1'b0, 1'b0, 199, 250, 1'b0,     0, 1'b0},
      '{200, 250, 2'b01, 1'b0, 1'b0, 200, 250, 1'b0,     0, 1'b1},
      '{200, 250, 2'b01, 1'b0, 1'b0, 201, 250, 1'b0,     0, 1'b1},
      '{200, 250, 2'b01, 1'b0, 1'b0, 202, 250, 1'b0,     1, 1'b1},
      '{200, 250, 2'b01, 1'b0, 1'b0, 200, 252, 1'b0,   320, 1'b1},
      '{200, 250, 2'b01, 1'b0, 1'b0, 840, 250, 1'b0,     0, 1'b0},
      '{200, 250, 2'b10, 1'b0, 1'b0, 204, 254, 1'b0,   321, 1'b1},
      '{200, 250, 2'b10, 1'b1, 1'b0, 207, 250, 1'b0,   318, 1'b1},
      '{200, 250, 2'b11, 1'b0, 1'b0, 201, 251, 1'b0,   321, 1'b1},
      '{200, 250, 2'b00, 1'b1, 1'b0, 200, 250, 1'b0,   319, 1'b1},
      '{200, 250, 2'b00, 1'b0, 1'b1, 200, 250, 1'b0, 76480, 1'b1},
      '{200, 250, 2'b00, 1'b1, 1'b1, 200, 250, 1'b0, 76799, 1'b1},
      '{200, 250, 2'b00, 1'b0, 1'b0, 200, 250, 1'b1,     0, 1'b0},
      '{200, 250, 2'b00, 1'b0, 1'b0, 205, 253, 1'b0,   965, 1'b1}
    };

    rst_n_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; bg_in = 12'h00F;
    hcount_in = '0; vcount_in = '0; blank_in = 1'b0;
    set_cfg(0, 0, 2'b00, 1'b0, 1'b0);
    hcount_in = 11'd2000; vcount_in = 10'd1000;
    repeat (3) @(posedge clk_in);
    #3;
    check("reset_addr", addr_out, 0);
    check("reset_pixel", pixel_out, 0);
    check("reset_inwin", in_window_out, 0);
    check("reset_fstart", frame_start_out, 0);
    rst_n_in = 1'b1;

    // Table: latch config at (0,0), present one pixel, then follow it down the pipe
    for (int i = 0; i < 20; i++) begin
      set_cfg(vecs[i].x0, vecs[i].y0, vecs[i].sc, vecs[i].mir, vecs[i].flp);
      step(0, 0, 1'b0);
      step(vecs[i].h, vecs[i].v, vecs[i].blk);
      check($sformatf("vec%0d_addr", i), addr_out, vecs[i].addr);
      repeat (3) step(2000, 1000, 1'b0);
      if (vecs[i].blk) exp_pix = 12'h000;
      else if (!vecs[i].inw) exp_pix = bg_in;
      else exp_pix = rgb12(ram_word(ADDR_W'(vecs[i].addr)));
      check($sformatf("vec%0d_inwin", i), in_window_out, vecs[i].inw);
      check($sformatf("vec%0d_pixel", i), pixel_out, exp_pix);
      check($sformatf("vec%0d_blank", i), blank_out, vecs[i].blk);
    end

    // Config hold: mid-frame x0 change is ignored until the next (0,0)
    set_cfg(200, 250, 2'b00, 1'b0, 1'b0);
    step(0, 0, 1'b0);
    x0_in = 11'd100;
    step(300, 400, 1'b0);
    step(200, 400, 1'b0);
    check("hold_addr", addr_out, 48000);
    step(0, 0, 1'b0);
    step(100, 250, 1'b0);
    check("hold_new_x0", addr_out, 0);
    step(419, 251, 1'b0);
    check("hold_new_edge", addr_out, 639);
    step(420, 251, 1'b0);
    check("hold_new_out", addr_out, 0);

    // hsync alignment: one-cycle pulse reappears exactly 4 cycles later
    step(2000, 1000, 1'b0);
    hsync_in = 1'b1;
    step(2000, 1000, 1'b0);
    hsync_in = 1'b0;
    step(2000, 1000, 1'b0);
    step(2000, 1000, 1'b0);
    check("hsync_lat3", hsync_out, 0);
    step(2000, 1000, 1'b0);
    check("hsync_lat4", hsync_out, 1);
    step(2000, 1000, 1'b0);
    check("hsync_lat5", hsync_out, 0);

    // frame_start pulse 4 cycles after (0,0)
    step(0, 0, 1'b0);
    step(2000, 1000, 1'b0);
    step(2000, 1000, 1'b0);
    check("fstart_lat2", frame_start_out, 0);
    step(2000, 1000, 1'b0);
    check("fstart_lat3", frame_start_out, 1);
    step(2000, 1000, 1'b0);
    check("fstart_lat4", frame_start_out, 0);

    // Mid-frame async reset drops outputs at once; defaults hold until next (0,0)
    set_cfg(200, 250, 2'b00, 1'b0, 1'b0);
    step(0, 0, 1'b0);
    hsync_in = 1'b1;
    repeat (4) step(400, 300, 1'b0);
    check("prerst_addr", addr_out, 16200);
    check("prerst_inwin", in_window_out, 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("rst_addr", addr_out, 0);
    check("rst_pixel", pixel_out, 0);
    check("rst_hsync", hsync_out, 0);
    check("rst_inwin", in_window_out, 0);
    hsync_in = 1'b0;
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    step(5, 3, 1'b0);
    check("postrst_addr", addr_out, 965);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
